mul16_seq: RTL and testbench

- Sequential 16-bit shift-and-add multiplier, product taken mod 2^16 (Hack word semantics).
- Sits directly downstream of the 16-bit ripple adder: one Add16 instance performs every accumulate step.
- Gives the ALU/CPU path a multiply without a combinational array.
- start/busy/done handshake, one partial product per clock.

---
 rtl/mul16_pkg.sv | 13 +
 rtl/mul16_seq_add16.sv | 20 ++
 rtl/mul16_seq.sv | 92 +++++++++
 tb/tb_mul16_seq.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mul16_pkg.sv
// Shared constants and state encoding for the sequential 16-bit multiplier.
package mul16_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_CNT = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01
  } state_e;

endpackage

// File: rtl/mul16_seq_add16.sv
// Add16: 16-bit ripple-carry adder, sum mod 2^16 (carry out is discarded).
module Add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] out
);

  logic [15:0] carry;

  // The carry out of the top bit is never needed, so only 15 ripple stages are built.
  always_comb begin
    carry = '0;
    for (int i = 0; i < 15; i++) begin
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign out = a ^ b ^ carry;

endmodule

// File: rtl/mul16_seq.sv
// mul16_seq: shift-and-add multiplier, product mod 2^16, one partial product per clock.
// Optional macro MUL16_EARLY_TERM_EN stops as soon as the remaining multiplier bits are zero.
module mul16_seq
  import mul16_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  state_e           state_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] out_q;
  logic             done_q;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] acc_d;
  logic             finish;

  Add16 u_add16 (
    .a   (acc_q),
    .b   (mcand_q),
    .out (sum)
  );

  always_comb begin
    acc_d = mplier_q[0] ? sum : acc_q;
`ifdef MUL16_EARLY_TERM_EN
    finish = (count_q == LAST_CNT) || (mplier_q[WIDTH-1:1] == '0);
`else
    finish = (count_q == LAST_CNT);
`endif
  end

  // A reset at any point drops the in-flight operation without producing a done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      out_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
            count_q  <= '0;
            state_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= {mcand_q[WIDTH-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
          if (finish) begin
            out_q   <= acc_d;
            done_q  <= 1'b1;
            count_q <= '0;
            state_q <= ST_IDLE;
          end else begin
            count_q <= count_q + 4'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign busy  = (state_q == ST_RUN);
  assign done  = done_q;
  assign out   = out_q;

endmodule

// File: tb/tb_mul16_seq.sv
// Self-checking bench for mul16_seq: directed cases plus randomized operations against a behavioural model.
module tb_mul16_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] out;

  int checks = 0;
  int errors = 0;

  mul16_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  always #5 clk = ~clk;

  function automatic int expLat(input logic [15:0] bv);
`ifdef MUL16_EARLY_TERM_EN
    int n = 1;
    for (int i = 0; i < 16; i++) if (bv[i]) n = i + 1;
    return n;
`else
    return 16;
`endif
  endfunction

  // Model: an accepted start schedules the product to appear after expLat(b) edges.
  int          mRemain = 0;
  logic [15:0] mPend = '0;
  logic [15:0] mOut = '0;
  logic        mDone = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mRemain = 0;
      mOut    = '0;
      mDone   = 1'b0;
    end else if (mRemain == 0) begin
      mDone = 1'b0;
      if (start) begin
        mRemain = expLat(b);
        mPend   = 16'((32'(a) * 32'(b)) & 32'hFFFF);
      end
    end else begin
      mRemain = mRemain - 1;
      if (mRemain == 0) begin
        mDone = 1'b1;
        mOut  = mPend;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("ready", 16'(ready), 16'(mRemain == 0));
    checkOutput("busy",  16'(busy),  16'(mRemain != 0));
    checkOutput("done",  16'(done),  16'(mDone));
    checkOutput("out",   out,        mOut);
  end

  task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv);
    a = av;
    b = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        return;
      end
    end
    checks++;
    errors++;
    $display("[TB] FAIL timeout: got no done expected done within 40 cycles");
  endtask

  task automatic runOp(input string name, input logic [15:0] av, input logic [15:0] bv,
                       input logic [15:0] expOut);
    int lat;
    applyStimulus(av, bv);
    waitDone(lat);
    checkOutput({name, "_lat"}, 16'(lat), 16'(expLat(bv)));
    checkOutput({name, "_out"}, out, expOut);
  endtask

  initial begin
    int lat;
    logic [15:0] ra, rb;

    repeat (3) @(negedge clk);
    checkOutput("reset_ready", 16'(ready), 16'd1);
    checkOutput("reset_out", out, 16'h0000);
    #2 rst_n = 1'b1;
    @(negedge clk);

    runOp("mul3x5", 16'd3, 16'd5, 16'h000F);
    @(negedge clk);
    checkOutput("done_low_after", 16'(done), 16'd0);

    runOp("wrapFFFF", 16'hFFFF, 16'hFFFF, 16'h0001);
    runOp("mul300", 16'd300, 16'd300, 16'h5F90);

    // Second start arrives while the first operation is still running.
    applyStimulus(16'd2, 16'd7);
    repeat (4) @(negedge clk);
    applyStimulus(16'd9, 16'd9);
    for (int k = 0; k < 40 && !done; k++) @(negedge clk);
    checkOutput("ignored_out", out, 16'h000E);
    for (int k = 0; k < 40 && !ready; k++) @(negedge clk);
    @(negedge clk);

    // Reset in the middle of an operation.
    applyStimulus(16'd4, 16'd4);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("midrst_ready", 16'(ready), 16'd1);
    checkOutput("midrst_done", 16'(done), 16'd0);
    checkOutput("midrst_out", out, 16'h0000);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    runOp("mul6x7", 16'd6, 16'd7, 16'h002A);

    // Back-to-back: the next start lands in the done cycle.
    runOp("b2b_first", 16'd3, 16'd5, 16'h000F);
    runOp("b2b_second", 16'd10, 16'd10, 16'h0064);

    runOp("bzero", 16'd1234, 16'd0, 16'h0000);
    runOp("a7b1", 16'd7, 16'd1, 16'h0007);
    runOp("msb_b", 16'd2, 16'h8000, 16'h0000);

    for (int n = 0; n < 50; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ra = 16'($urandom);
      rb = 16'($urandom) >> $urandom_range(0, 15);
      applyStimulus(ra, rb);
      if ($urandom_range(0, 1) == 1) begin
        a = 16'($urandom);
        b = 16'($urandom);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (done) lat = 0;
        else waitDone(lat);
      end else begin
        waitDone(lat);
      end
      checkOutput("rand_out", out, 16'((32'(ra) * 32'(rb)) & 32'hFFFF));
      for (int k = 0; k < 40 && !ready; k++) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
